// File: rtl/registers_term_multi.sv
// rtl/registers_term_multi.sv - register-cycle terminator with per-channel wait states and HOLD stall (optional REGTERM_TIMEOUT_EN)
module registers_term_multi #(
    parameter int                NCH       = 4,
    parameter int                CW        = 4,
    parameter logic [NCH*CW-1:0] WAIT_RD   = {NCH{CW'(3)}},
    parameter logic [NCH*CW-1:0] WAIT_WR   = {NCH{CW'(3)}},
    parameter int                TO_CYCLES = 64,
    parameter int                TOW       = 7
) (
    input  logic           CPUCLK,
    input  logic           RST_,
    input  logic           AS_,
    input  logic           R_W,
    input  logic [NCH-1:0] CS_,
    input  logic [NCH-1:0] HOLD,
    output logic           REG_DSK_,
    output logic           BERR_,
    output logic [NCH-1:0] ACTIVE_CH,
    output logic           CYC_DONE
);

    typedef enum logic [1:0] {ST_IDLE, ST_COUNT, ST_ACK} state_t;

    state_t         state, state_nxt;
    logic [CW-1:0]  count, count_nxt;
    logic           reg_dsk_nxt;
    logic           cyc_done_nxt;
    logic [NCH-1:0] active_nxt;
    logic [NCH-1:0] sel_oh;
    logic [CW-1:0]  sel_wait;
    logic           hold_act;

`ifdef REGTERM_TIMEOUT_EN
    logic [TOW-1:0] to_cnt, to_cnt_nxt;
    logic           berr_nxt;
    logic           to_hit;

    assign to_hit = (to_cnt == TOW'(TO_CYCLES - 1));
`else
    logic unused_cfg;

    assign unused_cfg = ^{TO_CYCLES[0], TOW[0]};
    assign BERR_      = 1'b1;
`endif

    // Lowest-index asserted select wins; scan from the top so the last hit is the lowest.
    always_comb begin
        sel_oh   = '0;
        sel_wait = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (!CS_[i]) begin
                sel_oh   = NCH'(1) << i;
                sel_wait = R_W ? WAIT_RD[i*CW +: CW] : WAIT_WR[i*CW +: CW];
            end
        end
    end

    assign hold_act = |(HOLD & ACTIVE_CH);

    always_comb begin
        state_nxt    = state;
        count_nxt    = count;
        reg_dsk_nxt  = REG_DSK_;
        active_nxt   = ACTIVE_CH;
        cyc_done_nxt = 1'b0;
`ifdef REGTERM_TIMEOUT_EN
        to_cnt_nxt   = to_cnt;
        berr_nxt     = BERR_;
`endif
        case (state)
            ST_IDLE: begin
                if (!AS_ && (|sel_oh)) begin
                    state_nxt  = ST_COUNT;
                    active_nxt = sel_oh;
                    count_nxt  = sel_wait;
`ifdef REGTERM_TIMEOUT_EN
                    to_cnt_nxt = '0;
`endif
                end
            end
            ST_COUNT: begin
                if (AS_) begin
                    state_nxt  = ST_IDLE;
                    active_nxt = '0;
                    count_nxt  = '0;
                end else if (hold_act) begin
`ifdef REGTERM_TIMEOUT_EN
                    if (to_hit) begin
                        berr_nxt  = 1'b0;
                        state_nxt = ST_ACK;
                    end else begin
                        to_cnt_nxt = to_cnt + TOW'(1);
                    end
`endif
                end else if (count != '0) begin
                    count_nxt = count - CW'(1);
                end else begin
                    reg_dsk_nxt = 1'b0;
                    state_nxt   = ST_ACK;
                end
            end
            ST_ACK: begin
                if (AS_) begin
                    // Only a real acknowledge reports completion; a timed-out cycle does not.
                    cyc_done_nxt = !REG_DSK_;
                    reg_dsk_nxt  = 1'b1;
                    active_nxt   = '0;
                    count_nxt    = '0;
                    state_nxt    = ST_IDLE;
`ifdef REGTERM_TIMEOUT_EN
                    berr_nxt     = 1'b1;
`endif
                end
            end
            default: begin
                state_nxt   = ST_IDLE;
                count_nxt   = '0;
                reg_dsk_nxt = 1'b1;
                active_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge CPUCLK or negedge RST_) begin
        if (!RST_) begin
            state     <= ST_IDLE;
            count     <= '0;
            REG_DSK_  <= 1'b1;
            ACTIVE_CH <= '0;
            CYC_DONE  <= 1'b0;
        end else begin
            state     <= state_nxt;
            count     <= count_nxt;
            REG_DSK_  <= reg_dsk_nxt;
            ACTIVE_CH <= active_nxt;
            CYC_DONE  <= cyc_done_nxt;
        end
    end

`ifdef REGTERM_TIMEOUT_EN
    always_ff @(posedge CPUCLK or negedge RST_) begin
        if (!RST_) begin
            to_cnt <= '0;
            BERR_  <= 1'b1;
        end else begin
            to_cnt <= to_cnt_nxt;
            BERR_  <= berr_nxt;
        end
    end
`endif

endmodule

// File: tb/tb_registers_term_multi.sv
// tb/tb_registers_term_multi.sv - directed self-checking bench for registers_term_multi
module tb_registers_term_multi;

    logic       CPUCLK;
    logic       RST_;
    logic       AS_;
    logic       R_W;
    logic [3:0] CS_;
    logic [3:0] HOLD;
    logic       REG_DSK_;
    logic       BERR_;
    logic [3:0] ACTIVE_CH;
    logic       CYC_DONE;

    int total;
    int fails;

    // ch3 rd=5, ch2 rd=3, ch1 rd=2, ch0 rd=3; ch0 wr=0, others wr=3
    registers_term_multi #(
        .NCH       (4),
        .CW        (4),
        .WAIT_RD   (16'h5323),
        .WAIT_WR   (16'h3330),
        .TO_CYCLES (8),
        .TOW       (7)
    ) dut (
        .CPUCLK    (CPUCLK),
        .RST_      (RST_),
        .AS_       (AS_),
        .R_W       (R_W),
        .CS_       (CS_),
        .HOLD      (HOLD),
        .REG_DSK_  (REG_DSK_),
        .BERR_     (BERR_),
        .ACTIVE_CH (ACTIVE_CH),
        .CYC_DONE  (CYC_DONE)
    );

    initial begin
        CPUCLK = 1'b0;
        forever #5 CPUCLK = ~CPUCLK;
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge CPUCLK);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        total = 0;
        fails = 0;
        RST_  = 1'b0;
        AS_   = 1'b1;
        R_W   = 1'b1;
        CS_   = 4'b1111;
        HOLD  = 4'b0000;
        tick(2);
        check("rst_dsk",    8'(REG_DSK_),  8'h1);
        check("rst_berr",   8'(BERR_),     8'h1);
        check("rst_active", 8'(ACTIVE_CH), 8'h0);
        check("rst_done",   8'(CYC_DONE),  8'h0);
        RST_ = 1'b1;
        tick(1);

        // 1: read ch2, W=3 -> acknowledge on edge 4
        R_W = 1'b1; CS_ = 4'b1011; AS_ = 1'b0;
        tick(1);
        check("t1_active", 8'(ACTIVE_CH), 8'h4);
        CS_ = 4'b1111; R_W = 1'b0;
        tick(3);
        check("t1_dsk_e3", 8'(REG_DSK_), 8'h1);
        tick(1);
        check("t1_dsk_e4", 8'(REG_DSK_), 8'h0);
        tick(2);
        check("t1_dsk_hold", 8'(REG_DSK_), 8'h0);
        AS_ = 1'b1;
        tick(1);
        check("t1_dsk_rel",  8'(REG_DSK_),  8'h1);
        check("t1_done",     8'(CYC_DONE),  8'h1);
        check("t1_idle_ch",  8'(ACTIVE_CH), 8'h0);
        tick(1);
        check("t1_done_off", 8'(CYC_DONE),  8'h0);

        // 2: write, all selects low -> ch0, W=0 -> edge 1
        R_W = 1'b0; CS_ = 4'b0000; AS_ = 1'b0;
        tick(1);
        check("t2_active", 8'(ACTIVE_CH), 8'h1);
        check("t2_dsk_e0", 8'(REG_DSK_),  8'h1);
        tick(1);
        check("t2_dsk_e1", 8'(REG_DSK_),  8'h0);
        AS_ = 1'b1; CS_ = 4'b1111;
        tick(1);
        check("t2_done",   8'(CYC_DONE),  8'h1);
        // no select -> foreign cycle, no response
        AS_ = 1'b0;
        tick(4);
        check("t2_nosel_ch",  8'(ACTIVE_CH), 8'h0);
        check("t2_nosel_dsk", 8'(REG_DSK_),  8'h1);
        AS_ = 1'b1;
        tick(1);

        // 3: read ch1, W=2, HOLD for 5 clocks -> edge 8
        R_W = 1'b1; CS_ = 4'b1101; AS_ = 1'b0;
        tick(1);
        check("t3_active", 8'(ACTIVE_CH), 8'h2);
        tick(1);
        HOLD = 4'b0010;
        tick(2);
        check("t3_dsk_e3", 8'(REG_DSK_), 8'h1);
        tick(3);
        HOLD = 4'b0000;
        tick(1);
        check("t3_dsk_e7", 8'(REG_DSK_), 8'h1);
        tick(1);
        check("t3_dsk_e8", 8'(REG_DSK_), 8'h0);
        AS_ = 1'b1; CS_ = 4'b1111;
        tick(1);
        check("t3_done",   8'(CYC_DONE), 8'h1);

        // 4: read ch3, W=5, abort after 2 clocks
        R_W = 1'b1; CS_ = 4'b0111; AS_ = 1'b0;
        tick(3);
        AS_ = 1'b1;
        tick(1);
        check("t4_abort_ch",  8'(ACTIVE_CH), 8'h0);
        check("t4_abort_dsk", 8'(REG_DSK_),  8'h1);
        check("t4_abort_dn0", 8'(CYC_DONE),  8'h0);
        tick(1);
        check("t4_abort_dn1", 8'(CYC_DONE),  8'h0);
        AS_ = 1'b0;
        tick(1);
        check("t4_re_active", 8'(ACTIVE_CH), 8'h8);
        tick(5);
        check("t4_re_dsk_e5", 8'(REG_DSK_),  8'h1);
        tick(1);
        check("t4_re_dsk_e6", 8'(REG_DSK_),  8'h0);
        AS_ = 1'b1; CS_ = 4'b1111;
        tick(1);
        check("t4_re_done",   8'(CYC_DONE),  8'h1);

        // 5: asynchronous reset while acknowledging
        R_W = 1'b0; CS_ = 4'b1110; AS_ = 1'b0;
        tick(2);
        check("t5_dsk_low", 8'(REG_DSK_), 8'h0);
        #1 RST_ = 1'b0;
        #1;
        check("t5_rst_dsk", 8'(REG_DSK_),  8'h1);
        check("t5_rst_ch",  8'(ACTIVE_CH), 8'h0);
        AS_ = 1'b1; CS_ = 4'b1111;
        tick(1);
        RST_ = 1'b1;
        tick(1);

        // 6: ch3 with HOLD stuck high
        R_W = 1'b1; CS_ = 4'b0111; HOLD = 4'b1000; AS_ = 1'b0;
        tick(1);
        tick(7);
        check("t6_berr_e7", 8'(BERR_), 8'h1);
        tick(1);
`ifdef REGTERM_TIMEOUT_EN
        check("t6_berr_e8", 8'(BERR_), 8'h0);
`else
        check("t6_berr_e8", 8'(BERR_), 8'h1);
`endif
        check("t6_dsk_e8",  8'(REG_DSK_), 8'h1);
        tick(10);
        check("t6_dsk_late", 8'(REG_DSK_), 8'h1);
`ifdef REGTERM_TIMEOUT_EN
        check("t6_berr_late", 8'(BERR_), 8'h0);
`else
        check("t6_berr_late", 8'(BERR_), 8'h1);
        check("t6_ch_late",   8'(ACTIVE_CH), 8'h8);
`endif
        AS_ = 1'b1; CS_ = 4'b1111;
        tick(1);
        check("t6_berr_rel", 8'(BERR_),     8'h1);
        check("t6_done",     8'(CYC_DONE),  8'h0);
        check("t6_idle_ch",  8'(ACTIVE_CH), 8'h0);
        HOLD = 4'b0000;
        tick(1);
        check("t6_done_off", 8'(CYC_DONE),  8'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
